// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment patterns, dp bit index and scan state type
package seg_pkg;

    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_A   = 8'h77;
    localparam logic [7:0] SEG_B   = 8'h7C;
    localparam logic [7:0] SEG_C   = 8'h39;
    localparam logic [7:0] SEG_D   = 8'h5E;
    localparam logic [7:0] SEG_E   = 8'h79;
    localparam logic [7:0] SEG_F   = 8'h71;
    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam int         SEG_DP  = 7;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display payload valid/ready handshake
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] din;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    logic                    din_valid;
    logic                    din_ready;

    modport master (
        output din, dp_in, lz_en, din_valid,
        input  din_ready
    );

    modport slave (
        input  din, dp_in, lz_en, din_valid,
        output din_ready
    );
endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - hex nibble + dp + blank to active-high segment pattern
module seg_hex_decode (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    import seg_pkg::*;

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
                default: seg = SEG_OFF;
            endcase
        end
        // a blanked leading zero still shows its decimal point
        seg[SEG_DP] = dp;
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan with frame-atomic payload update
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit SEG_ACT_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        in_if,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_done
);
    import seg_pkg::*;

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;

    logic [4*NUM_DIGITS-1:0] shadow_din;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_lz;
    logic [4*NUM_DIGITS-1:0] pend_din;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_lz;
    logic                    pend_full;

    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_q;
    logic                    fd_q;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [7:0]              dec_seg;

    // digits stay blank from the top down while every nibble so far is zero
    always_comb begin
        lz_blank = '0;
        zero_run = shadow_lz;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (shadow_din[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run && (k != 0);
        end
    end

    seg_hex_decode u_dec (
        .nibble (shadow_din[{idx, 2'b00} +: 4]),
        .dp     (shadow_dp[idx]),
        .blank  (lz_blank[idx]),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            shadow_din <= '0;
            shadow_dp  <= '0;
            shadow_lz  <= 1'b0;
            pend_din   <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_full  <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_q      <= '0;
            fd_q       <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            if (in_if.din_valid && !pend_full) begin
                pend_din  <= in_if.din;
                pend_dp   <= in_if.dp_in;
                pend_lz   <= in_if.lz_en;
                pend_full <= 1'b1;
            end
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        dig_q <= NUM_DIGITS'(1) << idx;
                        seg_q <= dec_seg;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        dig_q <= '0;
                        seg_q <= SEG_OFF;
                        if (idx == IDX_LAST) begin
                            idx  <= '0;
                            fd_q <= 1'b1;
                            // transfers and swaps are exclusive: a transfer needs pend_full low
                            if (pend_full) begin
                                shadow_din <= pend_din;
                                shadow_dp  <= pend_dp;
                                shadow_lz  <= pend_lz;
                                pend_full  <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

    assign in_if.din_ready = ~pend_full;
    assign seg             = seg_q ^ {8{SEG_ACT_LOW}};
    assign dig_sel         = dig_q ^ {NUM_DIGITS{SEG_ACT_LOW}};
    assign frame_done      = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int BL = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   seg;
    logic [N-1:0] dig_sel;
    logic         frame_done;
    int           total = 0;
    int           bad   = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .SEG_ACT_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (bus.slave),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({name, " frame_done seen"}, 32'(frame_done), 32'd1);
        chk({name, " ready at boundary"}, 32'(bus.din_ready), 32'd1);
    endtask

    task automatic load(input string name, input logic [15:0] d, input logic [3:0] dp, input logic lz);
        int n;
        n = 0;
        while (bus.din_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({name, " ready before load"}, 32'(bus.din_ready), 32'd1);
        bus.din       = d;
        bus.dp_in     = dp;
        bus.lz_en     = lz;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk({name, " ready drops"}, 32'(bus.din_ready), 32'd0);
    endtask

    task automatic capture(input int cycles, output logic [31:0] got);
        logic [N-1:0] oh;
        got = '1;
        for (int i = 0; i < cycles; i++) begin
            step();
            for (int d = 0; d < N; d++) begin
                oh    = '0;
                oh[d] = 1'b1;
                if (dig_sel === oh) got[d*8 +: 8] = seg;
            end
        end
    endtask

    task automatic check_frame(input string name, input int cycles, input logic [31:0] want);
        logic [31:0] got;
        capture(cycles, got);
        for (int d = 0; d < N; d++)
            chk($sformatf("%s digit%0d", name, d), 32'(got[d*8 +: 8]), 32'(want[d*8 +: 8]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        logic [12:0] want;
        logic [N-1:0] oh;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'h065B4F66};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 32'h00006D3F};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'h0000003F};
        vecs[3] = '{16'hABEF, 4'b0100, 1'b0, 32'h77FC7971};
        vecs[4] = '{16'h0008, 4'b1000, 1'b1, 32'h8000007F};
        vecs[5] = '{16'h0900, 4'b0000, 1'b1, 32'h006F3F3F};

        bus.din = '0; bus.dp_in = '0; bus.lz_en = 1'b0; bus.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dig_sel", 32'(dig_sel), 32'd0);
        chk("reset seg", 32'(seg), 32'h00);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset din_ready", 32'(bus.din_ready), 32'd1);

        // free-running scan: 2 frames after reset release, {dig_sel, seg, frame_done}
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step();
            want = '0;
            if (k >= 2) begin
                t = (k - 2) % 24;
                if (t % 6 < 4) begin
                    oh = '0;
                    oh[t / 6] = 1'b1;
                    want = {oh, 8'h3F, 1'b0};
                end else begin
                    want = {4'b0000, 8'h00, (t == 22)};
                end
            end
            chk($sformatf("scan edge%0d", k), 32'({dig_sel, seg, frame_done}), 32'(want));
        end

        for (int i = 0; i < 6; i++) begin
            repeat (5) step();
            load($sformatf("vec%0d", i), vecs[i].din, vecs[i].dp, vecs[i].lz);
            wait_fd($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), 23, vecs[i].exp);
        end

        // transfer on the boundary edge itself lands one frame late
        load("bnd", 16'h4321, 4'b0000, 1'b0);
        chk("bnd frame_done", 32'(frame_done), 32'd1);
        check_frame("bnd old", 23, 32'h006F3F3F);
        wait_fd("bnd");
        check_frame("bnd new", 23, 32'h664F5B06);

        // back-to-back payloads with valid held high
        repeat (5) step();
        chk("b2b ready", 32'(bus.din_ready), 32'd1);
        bus.din = 16'h5555; bus.dp_in = '0; bus.lz_en = 1'b0; bus.din_valid = 1'b1;
        step();
        chk("b2b first taken", 32'(bus.din_ready), 32'd0);
        bus.din = 16'h7777;
        wait_fd("b2b a");
        step();
        bus.din_valid = 1'b0;
        chk("b2b second taken", 32'(bus.din_ready), 32'd0);
        check_frame("b2b a", 22, 32'h6D6D6D6D);
        wait_fd("b2b b");
        check_frame("b2b b", 23, 32'h07070707);

        // asynchronous reset mid-DRIVE with a payload pending
        repeat (5) step();
        load("rst", 16'h9999, 4'b1111, 1'b0);
        chk("rst pre dig_sel", 32'(dig_sel), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst dig_sel", 32'(dig_sel), 32'd0);
        chk("rst seg", 32'(seg), 32'h00);
        chk("rst din_ready", 32'(bus.din_ready), 32'd1);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst edge1 dig_sel", 32'(dig_sel), 32'd0);
        step();
        chk("rst edge2 dig_sel", 32'(dig_sel), 32'h1);
        chk("rst edge2 seg", 32'(seg), 32'h3F);
        wait_fd("rst");
        check_frame("rst", 23, 32'h3F3F3F3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-select 7-segment display. It drives one shared segment bus (seg[7:0]) and walks a one-hot digit-select across NUM_DIGITS positions. Each digit gets a fixed drive (dwell) window, and a blanking gap separates digits to suppress ghosting. New display content is accepted through a valid/ready handshake and takes effect atomically at frame boundaries, so the upstream counter/clock logic never causes tearing.

Parameters:
NUM_DIGITS, 4, number of digit positions (legal 1..8); digit 0 = least significant/rightmost.
DWELL_CYCLES, 1000, clk cycles each digit is driven (>=1).
BLANK_CYCLES, 16, clk cycles all digits are off between digits (>=1).
SEG_ACT_LOW, 0, 1 inverts seg and dig_sel at the pins (common-anode boards).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
din  in  4*NUM_DIGITS  hex nibble per digit; nibble k = digit k.
dp_in  in  NUM_DIGITS  decimal point per digit.
lz_en  in  1  leading-zero suppression; captured together with din.
din_valid  in  1  producer has a new frame payload.
din_ready  out  1  controller can accept a payload.
seg  out  8  bit0..6 = segments a..g, bit7 = dp; registered.
dig_sel  out  NUM_DIGITS  one-hot digit enable; registered.
frame_done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (rst low, async):
  - state=BLANK, idx=0, phase counter=0.
  - shadow and pending payload = all zero, lz=0; pending empty.
  - seg=off, dig_sel=0, frame_done=0, din_ready=1.
  - Assertion mid-operation takes effect immediately and discards any pending payload.
- FSM states:
  - BLANK: dig_sel=0, seg=off, lasts exactly BLANK_CYCLES. Then go to DRIVE.
  - DRIVE: dig_sel=onehot(idx), seg=decode(shadow[idx]), lasts exactly DWELL_CYCLES. Then go to BLANK with idx+1; idx wraps NUM_DIGITS-1 -> 0.
- Timing:
  - The first edge after reset release is BLANK cycle 1.
  - dig_sel becomes onehot(0) after edge BLANK_CYCLES.
  - Frame period = NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES) cycles, with no drift.
- Frame boundary (DRIVE of idx NUM_DIGITS-1 -> BLANK):
  - frame_done=1 for exactly the first BLANK cycle.
  - If pending is full, shadow<=pending at that same edge and pending empties (din_ready=1 in that cycle).
  - The next digit-0 DRIVE shows the new data.
- Handshake:
  - din_ready = ~pending_full.
  - A transfer occurs on an edge where din_valid&&din_ready; it captures din, dp_in and lz_en into pending, and din_ready drops the next cycle.
  - A transfer on the boundary edge itself goes into pending, not shadow, and is displayed one frame later. There is no bypass.
  - din_valid while din_ready=0 is ignored; the producer holds.
- Decode: hex 0-F -> 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (a..g); dp ORs 0x80.
- Leading-zero suppression (lz=1): digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked (seg=0x00, dp still shown) until the first nonzero nibble. Digit 0 is never blanked. dig_sel sequencing is unchanged.
- SEG_ACT_LOW=1 inverts seg and dig_sel after registering; "off" then means all ones.
- Counters are $clog2-sized. No arithmetic overflow exists beyond the wraps described above.

Decomposition:
- Package seg_pkg: SEG_0..SEG_F and SEG_OFF constants, SEG_DP bit index, scan state typedef (BLANK, DRIVE).
- One sub-module: seg_hex_decode, combinational 4-bit nibble + dp + blank -> 8-bit segment pattern. It is shared with the existing counter display path.

Test Plan:
- All scenarios use NUM_DIGITS=4, DWELL=4, BLANK=2, SEG_ACT_LOW=0; frame period = 24 cycles.
- Reset release, no load -> dig_sel sequence 0000×2, 0001×4, 0000×2, 0010×4, 0000×2, 0100×4, 0000×2, 1000×4, repeating. seg=0x3F during every DRIVE. frame_done pulses every 24 cycles.
- din=16'h1234, dp=0, lz=0, valid for 1 cycle mid-frame -> din_ready=0 until the next frame_done. The following frame shows digit0=0x66, digit1=0x4F, digit2=0x5B, digit3=0x06.
- din=16'h0050, lz=1 -> digit3=digit2=0x00, digit1=0x6D, digit0=0x3F. Then din=16'h0000, lz=1 -> digits 3..1=0x00, digit0=0x3F.
- din=16'hABEF, dp=4'b0100 -> digit0=0x71, digit1=0x79, digit2=0xFC, digit3=0x77.
- Two payloads offered back-to-back (valid held high) -> the second is accepted only in the frame_done cycle and is displayed exactly one frame after the first.
- rst pulled low mid-DRIVE between edges -> dig_sel=0, seg=0x00 immediately, din_ready=1, pending lost. After release, scan restarts at BLANK/idx 0 and all digits show 0x3F.
